// File: rtl/mult_pipe_ctrl_pkg.sv
// Shared definitions for the multiply pipeline sequencer: default sizes and
// write-port arbiter state encoding.
package mult_pipe_ctrl_pkg;

   localparam int MULT_STAGES   = 5;
   localparam int MULT_REG_ADDR = 5;

   typedef enum logic {
      MPRI = 1'b0,
      APRI = 1'b1
   } arb_state_e;

endpackage

// File: rtl/mult_pipe_ctrl_if.sv
// Decode / writeback handshake bundle between the multiply sequencer and the
// surrounding pipeline.
interface mult_pipe_ctrl_if
   import mult_pipe_ctrl_pkg::*;
#(
   parameter int STAGES   = MULT_STAGES,
   parameter int REG_ADDR = MULT_REG_ADDR,
   parameter int CNT_W    = $clog2(STAGES + 1)
);

   logic                issue_valid;
   logic [REG_ADDR-1:0] issue_dst;
   logic                issue_regwrite;
   logic                issue_ready;
   logic [REG_ADDR-1:0] src_a;
   logic [REG_ADDR-1:0] src_b;
   logic                hazard_stall;
   logic                alu_wb_valid;
   logic                alu_wb_grant;
   logic [STAGES-1:0]   stage_we;
   logic                mult_wb_valid;
   logic [REG_ADDR-1:0] mult_wb_dst;
   logic                busy;
   logic [CNT_W-1:0]    inflight_cnt;

   modport master (
      output issue_valid, issue_dst, issue_regwrite, src_a, src_b, alu_wb_valid,
      input  issue_ready, hazard_stall, alu_wb_grant, stage_we,
             mult_wb_valid, mult_wb_dst, busy, inflight_cnt
   );

   modport slave (
      input  issue_valid, issue_dst, issue_regwrite, src_a, src_b, alu_wb_valid,
      output issue_ready, hazard_stall, alu_wb_grant, stage_we,
             mult_wb_valid, mult_wb_dst, busy, inflight_cnt
   );

endinterface

// File: rtl/mult_pipe_ctrl_wb_port_arbiter.sv
// Two-requester arbiter for the single register-file write port; alternates
// priority on back-to-back conflicts so neither side waits more than a cycle.
module wb_port_arbiter
   import mult_pipe_ctrl_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic mult_req,
   input  logic alu_req,
   output logic mult_grant,
   output logic alu_grant,
   output logic freeze
);

   arb_state_e state;
   logic       conflict;

   assign conflict = mult_req & alu_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MPRI;
      end else if (conflict && state == MPRI) begin
         state <= APRI;
      end else begin
         state <= MPRI;
      end
   end

   // Grants must answer this cycle's requests, so they decode from state here.
   always_comb begin
      mult_grant = 1'b0;
      alu_grant  = 1'b0;
      freeze     = 1'b0;
      if (!reset) begin
         if (!conflict) begin
            mult_grant = mult_req;
            alu_grant  = alu_req;
         end else if (state == MPRI) begin
            mult_grant = 1'b1;
         end else begin
            alu_grant = 1'b1;
            freeze    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_pipe_ctrl.sv
// Multiply pipeline sequencer: per-stage valid/dst tracking, stage load
// enables, RAW hazard detection and write-port arbitration with the ALU.
module mult_pipe_ctrl
   import mult_pipe_ctrl_pkg::*;
#(
   parameter int STAGES   = MULT_STAGES,
   parameter int REG_ADDR = MULT_REG_ADDR,
   parameter int CNT_W    = $clog2(STAGES + 1)
)(
   input logic             clk,
   input logic             reset,
   mult_pipe_ctrl_if.slave bus
);

   localparam int TAIL = STAGES - 1;

   logic [STAGES-1:0]   v;
   logic [STAGES-1:0]   rw;
   logic [REG_ADDR-1:0] dst [STAGES];

   logic             advance;
   logic             freeze;
   logic             tail_req;
   logic             mult_grant;
   logic             alu_grant;
   logic             hit_a;
   logic             hit_b;
   logic [CNT_W-1:0] cnt;

   assign tail_req = v[TAIL] & rw[TAIL];

   wb_port_arbiter u_arb (
      .clk        (clk),
      .reset      (reset),
      .mult_req   (tail_req),
      .alu_req    (bus.alu_wb_valid),
      .mult_grant (mult_grant),
      .alu_grant  (alu_grant),
      .freeze     (freeze)
   );

   assign advance = ~reset & ~freeze;

   always_ff @(posedge clk) begin
      if (reset) begin
         v  <= '0;
         rw <= '0;
         for (int unsigned i = 0; i < STAGES; i++) begin
            dst[i] <= '0;
         end
      end else if (advance) begin
         v[0]   <= bus.issue_valid;
         rw[0]  <= bus.issue_regwrite;
         dst[0] <= bus.issue_dst;
         for (int unsigned i = 1; i < STAGES; i++) begin
            v[i]   <= v[i-1];
            rw[i]  <= rw[i-1];
            dst[i] <= dst[i-1];
         end
      end
   end

   // The tail is included: its result is not bypassed to decode.
   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         if (v[i] && rw[i] && dst[i] == bus.src_a) hit_a = 1'b1;
         if (v[i] && rw[i] && dst[i] == bus.src_b) hit_b = 1'b1;
      end
   end

   always_comb begin
      cnt = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         cnt = cnt + CNT_W'(v[i]);
      end
   end

   assign bus.issue_ready   = advance;
   assign bus.stage_we      = {STAGES{advance}};
   assign bus.hazard_stall  = ~reset & ((hit_a & (bus.src_a != '0)) |
                                        (hit_b & (bus.src_b != '0)));
   assign bus.mult_wb_valid = tail_req & mult_grant & ~reset;
   assign bus.mult_wb_dst   = v[TAIL] ? dst[TAIL] : '0;
   assign bus.alu_wb_grant  = bus.alu_wb_valid & alu_grant & ~reset;
   assign bus.busy          = |v;
   assign bus.inflight_cnt  = cnt;

endmodule
